// File: rtl/round_pkg.sv
// Shared constants, frame-state encoding and beat-count helper for the
// streaming Round() pipeline (round_poly_pipe and round_lane).
package round_pkg;

    localparam int W_DEF       = 13;
    localparam int Q_SNTRUP757 = 5167;
    localparam int P_SNTRUP757 = 757;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    // Number of beats needed to carry p coefficients, lanes per beat.
    function automatic int beats(input int p, input int lanes);
        return (p + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/round_poly_pipe_if.sv
// Stream bundle for round_poly_pipe: input beat channel and output beat
// channel, each with a valid/ready handshake.
interface round_poly_pipe_if
    import round_pkg::*;
#(
    parameter int LANES = 1,
    parameter int W     = W_DEF
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_data;
    logic                 out_last;

    // Producer/consumer side (drives input beats, accepts output beats).
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // Pipeline side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/round_lane.sv
// One lane of the Round() datapath: centre-lift, mod-3 residue, snap to the
// nearest multiple of 3 and return to canonical form. Three register stages,
// all advancing together on adv_i. Build option ROUND_RANGE_CHK_EN adds an
// x >= Q comparator that zeroes the lane and reports it on bad_o.
module round_lane
    import round_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int Q = Q_SNTRUP757
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         adv_i,
    input  logic [W-1:0] x_i,
    input  logic         kill_i,
    output logic         bad_o,
    output logic [W-1:0] y_o
);
    localparam logic [W-1:0]      HALF_W  = W'((Q - 1) / 2);
    localparam logic [W-1:0]      Q_W     = W'(Q);
    localparam logic signed [W:0] Q_S     = (W+1)'(Q);
    localparam logic signed [W:0] THREE_S = (W+1)'(3);
    localparam logic signed [W:0] ONE_S   = (W+1)'(1);

    logic signed [W:0] s1_q, s1_d, s2_q;
    logic              k1_q, k1_d, k2_q;
    logic [1:0]        r2_q, r2_d;
    logic signed [W:0] rem, y3, c3;
    logic [W-1:0]      y_q, y_d;
    logic              bad;

    // Stage 1 input side: optional range check, then centre-lift into signed form.
    always_comb begin
        bad = 1'b0;
`ifdef ROUND_RANGE_CHK_EN
        bad = (x_i >= Q_W);
`endif
        k1_d = kill_i | bad;
        s1_d = (x_i > HALF_W) ? (signed'({1'b0, x_i}) - Q_S) : signed'({1'b0, x_i});
    end

    // Stage 2 input side: residue mod 3 folded to 0..2 even for negative values.
    always_comb begin
        rem  = s1_q % THREE_S;
        r2_d = (rem < 0) ? 2'(rem + THREE_S) : 2'(rem);
    end

    // Stage 3 input side: snap to nearest multiple of 3, back to 0..Q-1, zero if killed.
    always_comb begin
        case (r2_q)
            2'd1:    y3 = s2_q - ONE_S;
            2'd2:    y3 = s2_q + ONE_S;
            default: y3 = s2_q;
        endcase
        c3  = (y3 < 0) ? (y3 + Q_S) : y3;
        y_d = k2_q ? '0 : c3[W-1:0];
    end

    // All three stages shift together; nothing moves while the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            k1_q <= 1'b0;
            s2_q <= '0;
            r2_q <= '0;
            k2_q <= 1'b0;
            y_q  <= '0;
        end else if (adv_i) begin
            s1_q <= s1_d;
            k1_q <= k1_d;
            s2_q <= s1_q;
            r2_q <= r2_d;
            k2_q <= k1_q;
            y_q  <= y_d;
        end
    end

    assign bad_o = bad;
    assign y_o   = y_q;

endmodule

// File: rtl/round_poly_pipe.sv
// Streaming Round() over a polynomial of P coefficients, LANES per beat.
// A frame FSM (IDLE/RUN/FLUSH/DONE) counts accepted beats, tags the final
// one with out_last and pulses done once it has left the pipe.
// Build option ROUND_RANGE_CHK_EN enables the sticky err range flag.
module round_poly_pipe
    import round_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int Q     = Q_SNTRUP757,
    parameter int P     = P_SNTRUP757,
    parameter int LANES = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    round_poly_pipe_if.slave bus,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int B          = beats(P, LANES);
    // Lanes at or above this index are padding on the final beat.
    localparam int LAST_LANES = P - (B - 1) * LANES;
    localparam int CW         = (B > 1) ? $clog2(B) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(B - 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               v1_q, v2_q, v3_q;
    logic               l1_q, l2_q, l3_q;
    logic               adv, in_ready, accept, last_beat, range_hit;
    logic [LANES-1:0]   bad_vec;
    logic [LANES*W-1:0] in_data_w, out_data_w;

    assign adv       = !v3_q || bus.out_ready;
    assign in_ready  = (state_q == RUN) && adv;
    assign accept    = bus.in_valid && in_ready;
    assign last_beat = (cnt_q == CNT_LAST);
    assign in_data_w = bus.in_data;
    assign range_hit = accept && (|bad_vec);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        localparam bit DEAD_ON_LAST = (gi >= LAST_LANES);
        logic kill, bad;

        assign kill = last_beat && DEAD_ON_LAST;

        round_lane #(.W(W), .Q(Q)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .adv_i  (adv),
            .x_i    (in_data_w[gi*W +: W]),
            .kill_i (kill),
            .bad_o  (bad),
            .y_o    (out_data_w[gi*W +: W])
        );

        // Padding lanes never raise the range error.
        assign bad_vec[gi] = bad && !kill;
    end

    // Frame sequencing: beat counting, final-beat detection, sticky error.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q | range_hit;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    cnt_d = cnt_q + CW'(1);
                    if (last_beat) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (v3_q && bus.out_ready && l3_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state, beat counter and error flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Valid and last flags travel alongside the lane data, stage for stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
            l1_q <= 1'b0; l2_q <= 1'b0; l3_q <= 1'b0;
        end else if (adv) begin
            v1_q <= accept;
            l1_q <= accept && last_beat;
            v2_q <= v1_q;
            l2_q <= l1_q;
            v3_q <= v2_q;
            l3_q <= l2_q;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v3_q;
    assign bus.out_last  = l3_q;
    assign bus.out_data  = out_data_w;
    assign busy          = (state_q == RUN) || (state_q == FLUSH);
    assign done          = (state_q == DONE);
    assign err           = err_q;

endmodule

// File: tb/tb_round_poly_pipe.sv
// Bench for round_poly_pipe: a LANES=1 and a LANES=4 instance checked against
// a Round() reference computed directly from the arithmetic definition.
// Build option ROUND_RANGE_CHK_EN adds the range-error scenario.
module tb_round_poly_pipe;
    import round_pkg::*;

    localparam int W  = 13;
    localparam int Q  = 5167;
    localparam int P  = 757;
    localparam int B4 = beats(P, 4);

    logic clk = 1'b0;
    logic rst, start1, start4;
    logic busy1, done1, err1, busy4, done4, err4;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    round_poly_pipe_if #(.LANES(1), .W(W)) bus1 ();
    round_poly_pipe_if #(.LANES(4), .W(W)) bus4 ();

    round_poly_pipe #(.W(W), .Q(Q), .P(P), .LANES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bus(bus1),
        .busy(busy1), .done(done1), .err(err1)
    );

    round_poly_pipe #(.W(W), .Q(Q), .P(P), .LANES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .bus(bus4),
        .busy(busy4), .done(done4), .err(err4)
    );

    // Reference Round(): centre-lift, pick the multiple of 3 within distance 1,
    // map negatives back by +Q. Out-of-range inputs give 0.
    function automatic int round_ref(input int x);
        int c, y;
        if (x >= Q) return 0;
        c = (x > (Q - 1) / 2) ? x - Q : x;
        y = c;
        for (int d = -1; d <= 1; d++) begin
            if (((c + d) % 3) == 0) y = c + d;
        end
        return (y < 0) ? y + Q : y;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if ({bus1.in_ready, bus1.out_valid, bus1.out_last, done1, busy1, err1} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctl1 got=%b exp=000000", {bus1.in_ready, bus1.out_valid, bus1.out_last, done1, busy1, err1});
        end
        n_cmp++;
        if (bus1.out_data !== '0) begin
            n_bad++; $display("FAIL reset_data1 got=%0d exp=0", bus1.out_data);
        end
        n_cmp++;
        if ({bus4.in_ready, bus4.out_valid, bus4.out_last, done4, busy4, err4} !== 6'b0) begin
            n_bad++; $display("FAIL reset_ctl4 got=%b exp=000000", {bus4.in_ready, bus4.out_valid, bus4.out_last, done4, busy4, err4});
        end
        n_cmp++;
        if (bus4.out_data !== '0) begin
            n_bad++; $display("FAIL reset_data4 got=%h exp=0", bus4.out_data);
        end
        n_cmp++;
        rst = 1'b0;
        @(posedge clk); #1;
        if (busy1 !== 1'b0 || bus1.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_idle got busy=%b in_ready=%b exp 0 0", busy1, bus1.in_ready);
        end
        n_cmp++;
        $display("reset: checked both instances idle");
    endtask

    task automatic test_vectors();
        int vin [7] = '{0, 1, 2, 5166, 5165, 2583, 2584};
        int vexp[7] = '{0, 0, 3, 0, 5164, 2583, 2584};
        bus1.out_ready = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        if (busy1 !== 1'b1) begin
            n_bad++; $display("FAIL vec_busy got=%b exp=1", busy1);
        end
        n_cmp++;
        for (int c = 0; c < 10; c++) begin
            bus1.in_valid = (c < 7);
            bus1.in_data  = (c < 7) ? 13'(vin[c]) : 13'd0;
            #1;
            if (c < 7) begin
                if (bus1.in_ready !== 1'b1) begin
                    n_bad++; $display("FAIL vec_in_ready c=%0d got=%b exp=1", c, bus1.in_ready);
                end
                n_cmp++;
            end
            if (c >= 3) begin
                if (bus1.out_valid !== 1'b1 || bus1.out_data !== 13'(vexp[c-3])) begin
                    n_bad++; $display("FAIL vec_out in=%0d got valid=%b data=%0d exp valid=1 data=%0d", vin[c-3], bus1.out_valid, bus1.out_data, vexp[c-3]);
                end
                n_cmp++;
                $display("vector: in=%0d out=%0d exp=%0d", vin[c-3], bus1.out_data, vexp[c-3]);
            end else begin
                if (bus1.out_valid !== 1'b0) begin
                    n_bad++; $display("FAIL vec_latency c=%0d got out_valid=%b exp=0", c, bus1.out_valid);
                end
                n_cmp++;
            end
            @(posedge clk); #1;
        end
        bus1.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        int q[$];
        int acc = 0, got = 0, last_cyc = -1, x, e;
        bit fin = 1'b0;
        bus1.out_ready = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            x = int'($urandom_range(0, Q - 1));
            bus1.in_valid = (acc < P);
            bus1.in_data  = 13'(x);
            #1;
            if (bus1.in_valid && bus1.in_ready) begin
                q.push_back(round_ref(x));
                acc++;
            end
            if (bus1.out_valid && bus1.out_ready) begin
                got++;
                e = (q.size() > 0) ? q.pop_front() : -1;
                if (bus1.out_data !== 13'(e) || bus1.out_last !== (got == P)) begin
                    n_bad++; $display("FAIL frame1_beat %0d got data=%0d last=%b exp data=%0d last=%b", got, bus1.out_data, bus1.out_last, e, (got == P));
                end
                n_cmp++;
                $display("frame1: beat %0d out=%0d exp=%0d last=%b", got, bus1.out_data, e, bus1.out_last);
                if (bus1.out_last) last_cyc = cyc;
            end
            if (last_cyc < 0) begin
                if (done1 !== 1'b0) begin
                    n_bad++; $display("FAIL frame1_early_done cyc=%0d got=1 exp=0", cyc);
                end
                n_cmp++;
            end else if (cyc == last_cyc + 1) begin
                if (done1 !== 1'b1 || busy1 !== 1'b0) begin
                    n_bad++; $display("FAIL frame1_done got done=%b busy=%b exp done=1 busy=0", done1, busy1);
                end
                n_cmp++;
            end else if (cyc == last_cyc + 2) begin
                if (done1 !== 1'b0) begin
                    n_bad++; $display("FAIL frame1_done_len got=%b exp=0", done1);
                end
                n_cmp++;
                fin = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus1.in_valid = 1'b0;
        if (!fin || got != P || acc != P || err1 !== 1'b0) begin
            n_bad++; $display("FAIL frame1_end got fin=%0d beats=%0d acc=%0d err=%b exp fin=1 beats=%0d acc=%0d err=0", fin, got, acc, err1, P, P);
        end
        n_cmp++;
    endtask

    task automatic test_abort();
        int acc = 0;
        bus1.out_ready = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int cyc = 0; cyc < 1000 && acc < 300; cyc++) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = 13'($urandom_range(0, Q - 1));
            #1;
            if (bus1.in_ready) acc++;
            @(posedge clk); #1;
        end
        if (acc != 300) begin
            n_bad++; $display("FAIL abort_feed got=%0d exp=300", acc);
        end
        n_cmp++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        if (bus1.in_ready !== 1'b0 || bus1.out_valid !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0) begin
            n_bad++; $display("FAIL abort_state got in_ready=%b out_valid=%b done=%b busy=%b exp all 0", bus1.in_ready, bus1.out_valid, done1, busy1);
        end
        n_cmp++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            if (done1 !== 1'b0 || bus1.out_valid !== 1'b0) begin
                n_bad++; $display("FAIL abort_quiet i=%0d got done=%b out_valid=%b exp 0 0", i, done1, bus1.out_valid);
            end
            n_cmp++;
        end
        bus1.in_valid = 1'b0;
        $display("abort: frame aborted after 300 beats");
    endtask

    task automatic test_lanes4_backpressure();
        logic [4*W-1:0] q[$];
        logic [4*W-1:0] d, ex, held, e;
        logic held_last;
        bit   hold = 1'b0, fin = 1'b0;
        int   acc = 0, got = 0, last_cyc = -1, x;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            d  = '0;
            ex = '0;
            for (int k = 0; k < 4; k++) begin
                x = int'($urandom_range(0, Q - 1));
                d[k*W +: W] = 13'(x);
                if (acc * 4 + k < P) ex[k*W +: W] = 13'(round_ref(x));
            end
            bus4.in_valid  = (acc < B4) && ($urandom_range(0, 3) != 0);
            bus4.in_data   = d;
            bus4.out_ready = 1'($urandom_range(0, 1));
            #1;
            if (hold) begin
                if (bus4.out_valid !== 1'b1 || bus4.out_data !== held || bus4.out_last !== held_last) begin
                    n_bad++; $display("FAIL stall_hold cyc=%0d got valid=%b data=%h exp valid=1 data=%h", cyc, bus4.out_valid, bus4.out_data, held);
                end
                n_cmp++;
            end
            if (bus4.in_valid && bus4.in_ready) begin
                q.push_back(ex);
                acc++;
            end
            if (bus4.out_valid && bus4.out_ready) begin
                got++;
                e = (q.size() > 0) ? q.pop_front() : '1;
                if (bus4.out_data !== e || bus4.out_last !== (got == B4)) begin
                    n_bad++; $display("FAIL frame4_beat %0d got data=%h last=%b exp data=%h last=%b", got, bus4.out_data, bus4.out_last, e, (got == B4));
                end
                n_cmp++;
                $display("frame4: beat %0d out=%h exp=%h last=%b", got, bus4.out_data, e, bus4.out_last);
                if (bus4.out_last) last_cyc = cyc;
            end
            hold      = bus4.out_valid && !bus4.out_ready;
            held      = bus4.out_data;
            held_last = bus4.out_last;
            if (last_cyc >= 0 && cyc == last_cyc + 1) begin
                if (done4 !== 1'b1 || busy4 !== 1'b0) begin
                    n_bad++; $display("FAIL frame4_done got done=%b busy=%b exp done=1 busy=0", done4, busy4);
                end
                n_cmp++;
                fin = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b1;
        if (!fin || got != B4 || q.size() != 0) begin
            n_bad++; $display("FAIL frame4_end got fin=%0d beats=%0d left=%0d exp fin=1 beats=%0d left=0", fin, got, q.size(), B4);
        end
        n_cmp++;
        @(posedge clk); #1;
    endtask

`ifdef ROUND_RANGE_CHK_EN
    task automatic test_range();
        int q[$];
        int acc = 0, got = 0, last_cyc = -1, bad_cyc = -1, x, e;
        bit fin = 1'b0;
        bus1.out_ready = 1'b1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            x = (acc == 9) ? Q : int'($urandom_range(0, Q - 1));
            bus1.in_valid = (acc < P);
            bus1.in_data  = 13'(x);
            #1;
            if (bad_cyc >= 0 && cyc > bad_cyc) begin
                if (err1 !== 1'b1) begin
                    n_bad++; $display("FAIL range_err_sticky cyc=%0d got=%b exp=1", cyc, err1);
                end
                n_cmp++;
            end else if (err1 !== 1'b0) begin
                n_bad++; $display("FAIL range_err_early cyc=%0d got=%b exp=0", cyc, err1);
                n_cmp++;
            end else begin
                n_cmp++;
            end
            if (bus1.in_valid && bus1.in_ready) begin
                q.push_back(round_ref(x));
                if (acc == 9) bad_cyc = cyc;
                acc++;
            end
            if (bus1.out_valid && bus1.out_ready) begin
                got++;
                e = (q.size() > 0) ? q.pop_front() : -1;
                if (bus1.out_data !== 13'(e)) begin
                    n_bad++; $display("FAIL range_beat %0d got=%0d exp=%0d", got, bus1.out_data, e);
                end
                n_cmp++;
                if (got == 10) $display("range: beat 10 out=%0d exp=%0d err=%b", bus1.out_data, e, err1);
                if (bus1.out_last) last_cyc = cyc;
            end
            if (last_cyc >= 0 && cyc == last_cyc + 2) begin
                fin = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus1.in_valid = 1'b0;
        if (!fin || err1 !== 1'b1) begin
            n_bad++; $display("FAIL range_end got fin=%0d err=%b exp fin=1 err=1", fin, err1);
        end
        n_cmp++;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        if (err1 !== 1'b0) begin
            n_bad++; $display("FAIL range_clear got=%b exp=0", err1);
        end
        n_cmp++;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_full_frame();
        test_abort();
        test_full_frame();
        test_lanes4_backpressure();
`ifdef ROUND_RANGE_CHK_EN
        test_range();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/round_poly_pipe.md
Name: round_poly_pipe

Overview:
- Parametrised, streaming successor to the single-coefficient rounding datapath used in Encap.
- Takes a polynomial of P coefficients in canonical Zq form (0..Q-1) and outputs Round(c): c centre-lifted, rounded to the nearest multiple of 3, then returned to canonical form.
- Processes LANES coefficients per beat through a 3-stage stall-able pipeline with valid/ready handshakes.
- A frame FSM counts beats and flags the final one.

Parameters:
- W, 13, coefficient width in bits.
- Q, 5167, modulus; must be odd, with (Q-1)/2 divisible by 3.
- P, 757, coefficients per polynomial.
- LANES, 1, coefficients per beat (1..8).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a frame; honoured only in IDLE.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  LANES*W  lane k at bits [k*W +: W].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*W  rounded coefficients, canonical 0..Q-1.
- out_last  out  1  high with the final beat of the frame.
- busy  out  1  high in RUN or FLUSH.
- done  out  1  one-cycle pulse when the frame completes.
- err  out  1  sticky range error (optional feature).

Behaviour:
- Reset (clk edge with rst=1): state=IDLE; all stage valids=0; beat counter=0; out_data=0; out_last=0; done=0; err=0. rst mid-frame aborts the frame; no done pulse.
- Beats per frame: B = ceil(P/LANES). On the last beat, lanes with index >= P - (B-1)*LANES carry don't-care input and output 0.
- Pipeline advance: adv = !v3 || out_ready. All three stages shift together when adv=1. No bubble squeezing is required.
- in_ready = (state==RUN) && adv.
- Latency: 3 cycles from input accept to out_valid with no backpressure. Sustains 1 beat/cycle.
- S1: centre-lift per lane. If x > (Q-1)/2 then s = x - Q, else s = x. s is signed, W+1 bits.
- S2: r = s mod 3, in {0,1,2}, non-negative residue for negative s as well.
- S3: y = s - 1 if r==1; y = s + 1 if r==2; y = s if r==0. Then y is mapped to canonical form: y < 0 gives y + Q. By construction |y| <= (Q-1)/2, so no overflow.
- Per-beat out_last is carried down the pipe alongside the data.
- FSM:
  - IDLE: start -> RUN, counter cleared.
  - RUN: counter increments on each accept. The accept with counter==B-1 -> FLUSH.
  - FLUSH: when out_valid && out_ready && out_last -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start outside IDLE is ignored. in_valid outside RUN is ignored (in_ready=0).
- Backpressure: while out_valid && !out_ready, out_data and out_last hold stable and no stage changes.

Optional Feature:
- Macro ROUND_RANGE_CHK_EN.
- Defined: any accepted lane (within the P valid coefficients) with x >= Q sets err. err stays set until rst or the next start. That lane's output is forced to 0.
- Undefined: err is tied 0, no comparators are built, and inputs are assumed in range.

Decomposition:
- Package round_pkg:
  - Default constants W_DEF, Q_SNTRUP757=5167, P_SNTRUP757=757.
  - State enum {IDLE, RUN, FLUSH, DONE}.
  - Function beats(P, LANES).
- One sub-module, round_lane: a single-lane 3-stage datapath with an adv input. The top instantiates LANES copies plus the FSM and counter.

Test Plan:
- LANES=1, inputs 0, 1, 2, 5166, 5165, 2583, 2584 -> outputs 0, 0, 3, 0, 5164, 2583, 2584, each 3 cycles after accept.
- Full frame, LANES=1, out_ready=1: 757 beats -> out_last on beat 757 only; done pulses exactly 1 cycle after that transfer; busy falls with done.
- LANES=4: B=190; last beat lanes 1..3 output 0. Randomised frame checked against a reference model of Round.
- out_ready toggling randomly at 50%: no beat lost or duplicated; out_data is stable whenever out_valid && !out_ready.
- rst asserted at beat 300 -> next cycle in_ready=0, out_valid=0, no done. A new start then runs a clean frame.
- With ROUND_RANGE_CHK_EN: input 5167 on beat 10 -> that output is 0, err=1 and stays set through frame end; the next start clears it.
